// File: rtl/psg_bus_writer.sv
// AY-3-8913 register bus master: FIFO of {rd,reg,data} commands played out as BDIR/BC1 cycles.
// Optional read phase enabled by defining PSG_WRITER_READ_EN.
module psg_bus_writer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int HOLD_CYCLES    = 2,
  parameter int GAP_CYCLES     = 1,
  parameter int SKIP_SAME_ADDR = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_reg,
  input  logic [7:0] in_data,
  input  logic       in_rd,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  output logic       bdir,
  output logic       bc1,
  output logic       busy,
  output logic       rd_valid,
  output logic [7:0] rd_data
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(HOLD_CYCLES + GAP_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam bit SKIP = (SKIP_SAME_ADDR != 0);

  typedef struct packed {
    logic       rd;
    logic [3:0] rg;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP_A,
    S_WRITE,
`ifdef PSG_WRITER_READ_EN
    S_READ,
`endif
    S_GAP_D
  } state_t;

  cmd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   fcnt_q;
  logic          full, empty, push, pop;
  cmd_t          head, cur_q;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cache_q;
  logic          cache_vld_q, cache_ld;
  state_t        head_st, cur_st;

  logic          bdir_d, bc1_d, oe_d;
  logic [7:0]    bus_d;

  assign full     = (fcnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty    = (fcnt_q == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rp_q];
  assign busy     = !empty || (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= '{rd: in_rd, rg: in_reg, data: in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wp_q <= AW'((32'(wp_q) + 1) % FIFO_DEPTH);
      if (pop)  rp_q <= AW'((32'(rp_q) + 1) % FIFO_DEPTH);
      if (push && !pop)      fcnt_q <= fcnt_q + 1'b1;
      else if (pop && !push) fcnt_q <= fcnt_q - 1'b1;
    end
  end

`ifdef PSG_WRITER_READ_EN
  assign head_st = head.rd ? S_READ : S_WRITE;
  assign cur_st  = cur_q.rd ? S_READ : S_WRITE;
`else
  logic unused_rd;
  assign unused_rd = ^{bus_in, head.rd, cur_q.rd};
  assign head_st = S_WRITE;
  assign cur_st  = S_WRITE;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    cache_ld = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          cnt_d = '0;
          if (SKIP && cache_vld_q && head.rg == cache_q)
            state_d = head_st;
          else
            state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cnt_q == HOLD_LAST) begin
          cache_ld = 1'b1;
          cnt_d    = '0;
          state_d  = HAS_GAP ? S_GAP_A : cur_st;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP_A: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = cur_st;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef PSG_WRITER_READ_EN
      S_WRITE, S_READ: begin
`else
      S_WRITE: begin
`endif
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = HAS_GAP ? S_GAP_D : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP_D: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop) cur_q <= head;
      if (cache_ld) begin
        cache_q     <= cur_q.rg;
        cache_vld_q <= 1'b1;
      end
    end
  end

  // Pins are registered from the state, so they trail it by one clock.
  always_comb begin
    bdir_d = 1'b0;
    bc1_d  = 1'b0;
    oe_d   = 1'b0;
    bus_d  = bus_out;
    case (state_q)
      S_ADDR: begin
        bdir_d = 1'b1;
        bc1_d  = 1'b1;
        oe_d   = 1'b1;
        bus_d  = {4'h0, cur_q.rg};
      end
      S_WRITE: begin
        bdir_d = 1'b1;
        oe_d   = 1'b1;
        bus_d  = cur_q.data;
      end
`ifdef PSG_WRITER_READ_EN
      S_READ: bc1_d = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bdir    <= 1'b0;
      bc1     <= 1'b0;
      bus_oe  <= 1'b0;
      bus_out <= '0;
    end else begin
      bdir    <= bdir_d;
      bc1     <= bc1_d;
      bus_oe  <= oe_d;
      bus_out <= bus_d;
    end
  end

`ifdef PSG_WRITER_READ_EN
  logic rd_fire_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_fire_q <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_fire_q <= (state_q == S_READ) && (cnt_q == HOLD_LAST);
      rd_valid  <= rd_fire_q;
      if (rd_fire_q) rd_data <= bus_in;
    end
  end
`else
  assign rd_valid = 1'b0;
  assign rd_data  = '0;
`endif

endmodule
